// File: rtl/conv_frame_sequencer_if.sv
// Image-memory read bus and window-buffer pixel stream of conv_frame_sequencer.
// The master side is the sequencer, and the slave side is the memory/window-buffer pair.
interface conv_frame_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              pix_valid;
    logic [7:0]        pix_data;
    logic [15:0]       pix_row;
    logic [15:0]       pix_col;
    logic              frame_last;

    modport master (
        output mem_rd_en, mem_rd_addr, pix_valid, pix_data, pix_row, pix_col, frame_last,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, pix_valid, pix_data, pix_row, pix_col, frame_last,
        output mem_rd_data
    );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Walks a zero-padded raster, reads interior pixels from image memory and streams one pixel per coordinate.
// Optional macro SEQ_PAD_VALUE_EN adds a pad_value input that is latched at start and used for border pixels.
module conv_frame_sequencer #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int PAD        = 1,
    parameter int ADDR_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
`ifdef SEQ_PAD_VALUE_EN
    input  logic [7:0]             pad_value,
`endif
    input  logic                   stall_in,
    output logic                   busy,
    output logic                   done,
    conv_frame_sequencer_if.master bus
);
    localparam int PW = IMG_WIDTH + 2 * PAD;
    localparam int PH = IMG_HEIGHT + 2 * PAD;
    localparam logic [15:0] COL_LAST = 16'(PW - 1);
    localparam logic [15:0] ROW_LAST = 16'(PH - 1);
    localparam logic [15:0] PAD_L    = 16'(PAD);
    localparam logic [15:0] WIDTH_L  = 16'(IMG_WIDTH);
    localparam logic [15:0] HEIGHT_L = 16'(IMG_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       row_reg, col_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              s1_valid_reg, s1_pad_reg, s1_last_reg;
    logic [15:0]       s1_row_reg, s1_col_reg;
    logic [7:0]        pad_pixel;
    logic              accept, issue, interior, last_coord;
    logic [15:0]       row_off, col_off;

`ifdef SEQ_PAD_VALUE_EN
    logic [7:0] pad_value_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_value_reg <= 8'h00;
        end else if (accept) begin
            pad_value_reg <= pad_value;
        end
    end

    assign pad_pixel = pad_value_reg;
`else
    assign pad_pixel = 8'h00;
`endif

    // Coordinates left of or above the image wrap to large offsets, so a single compare
    // per axis gives the interior test. This also works when PAD is 0.
    assign row_off    = row_reg - PAD_L;
    assign col_off    = col_reg - PAD_L;
    assign interior   = (row_off < HEIGHT_L) && (col_off < WIDTH_L);
    assign last_coord = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    assign accept     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign issue      = (state_reg == ST_RUN) && !stall_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (issue && last_coord) state_next = ST_DRAIN;
            ST_DRAIN: if (bus.frame_last) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_RUN : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
        done            = (state_reg == ST_DONE);
        bus.mem_rd_en   = issue && interior;
        bus.mem_rd_addr = addr_reg;
    end

    // The running address advances only on interior issues, so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg  <= 16'd0;
            col_reg  <= 16'd0;
            addr_reg <= '0;
        end else if (accept) begin
            row_reg  <= 16'd0;
            col_reg  <= 16'd0;
            addr_reg <= base_addr;
        end else if (issue) begin
            if (col_reg == COL_LAST) begin
                col_reg <= 16'd0;
                row_reg <= row_reg + 16'd1;
            end else begin
                col_reg <= col_reg + 16'd1;
            end
            if (interior) begin
                addr_reg <= addr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_pad_reg   <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_row_reg   <= 16'd0;
            s1_col_reg   <= 16'd0;
        end else begin
            s1_valid_reg <= issue;
            if (issue) begin
                s1_pad_reg  <= !interior;
                s1_last_reg <= last_coord;
                s1_row_reg  <= row_reg;
                s1_col_reg  <= col_reg;
            end
        end
    end

    // Memory data arrives while the coordinate sits in S1, so the output stage merges it here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pix_valid  <= 1'b0;
            bus.frame_last <= 1'b0;
            bus.pix_data   <= 8'h00;
            bus.pix_row    <= 16'd0;
            bus.pix_col    <= 16'd0;
        end else begin
            bus.pix_valid  <= s1_valid_reg;
            bus.frame_last <= s1_valid_reg && s1_last_reg;
            if (s1_valid_reg) begin
                bus.pix_data <= s1_pad_reg ? pad_pixel : bus.mem_rd_data;
                bus.pix_row  <= s1_row_reg;
                bus.pix_col  <= s1_col_reg;
            end
        end
    end
endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller that sequences the 3x3 window buffer.
- On `start` it walks a padded raster of (IMG_HEIGHT+2*PAD) x (IMG_WIDTH+2*PAD) coordinates.
  - Interior coordinates: issues image-memory reads.
  - Border coordinates: injects pad pixels.
- Emits one strobed pixel per coordinate on the window buffer's valid_in/pixel_in interface.
- Downstream window buffer must be instantiated with IMG_WIDTH = IMG_WIDTH+2*PAD and IMG_HEIGHT = IMG_HEIGHT+2*PAD.

Parameters:
IMG_WIDTH, 8, unpadded image width in pixels (>=1)
IMG_HEIGHT, 8, unpadded image height in pixels (>=1)
PAD, 1, border width in pixels on every side (0..3)
ADDR_W, 16, image memory address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle frame start request
base_addr  input  ADDR_W  address of pixel (0,0); latched on accepted start
stall_in  input  1  pause request; gates new coordinate issue only
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after last pixel emitted
mem_rd_en  output  1  image memory read strobe
mem_rd_addr  output  ADDR_W  read address; valid with mem_rd_en
mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en
pix_valid  output  1  pixel strobe to window buffer valid_in
pix_data  output  8  pixel to window buffer pixel_in
pix_row  output  16  padded row of emitted pixel
pix_col  output  16  padded column of emitted pixel
frame_last  output  1  high with pix_valid on final pixel of frame

Behaviour:
- Reset (async, `rst`=1): state IDLE.
  - All outputs 0: busy, done, mem_rd_en, mem_rd_addr, pix_valid, pix_data, pix_row, pix_col, frame_last.
  - Counters and pipeline valids cleared.
  - Reset mid-frame abandons the frame, and no done pulse follows.
- Derived constants: PW = IMG_WIDTH+2*PAD, PH = IMG_HEIGHT+2*PAD, N = PW*PH.
- FSM IDLE -> RUN: on start=1 while IDLE.
  - Latch base_addr.
  - Clear row/col counters (r, c) to (0,0).
  - busy=1 from the next cycle.
  - start while busy is ignored.
- RUN, issue stage: each cycle with stall_in=0 issues coordinate (r,c) into stage S1, then advances c.
  - When c=PW-1, c wraps to 0 and r increments.
- Interior coordinate: PAD<=r<PAD+IMG_HEIGHT and PAD<=c<PAD+IMG_WIDTH.
  - Issue asserts mem_rd_en=1.
  - mem_rd_addr = base + (r-PAD)*IMG_WIDTH + (c-PAD), produced by a running address counter (no multiplier).
  - The counter increments only on interior issues.
- Pad coordinate: mem_rd_en=0, and S1 carries the pad flag.
- stall_in=1: no issue, counters hold, mem_rd_en=0. Already-issued coordinates still drain, so up to 2 pix_valid strobes follow stall assertion.
- RUN -> DRAIN: in the cycle coordinate (PH-1,PW-1) issues.
- Output stage: registered from S1 every cycle.
  - pix_valid = S1.valid.
  - pix_data = pad ? 0 : mem_rd_data.
  - pix_row/pix_col = S1 coordinate.
  - frame_last = S1.valid && coordinate == (PH-1,PW-1).
- Latency: coordinate issued in cycle k -> pix_valid high in cycle k+2.
- DRAIN -> IDLE: the cycle after frame_last is seen.
  - done=1 for that single cycle.
  - busy=0 in the same cycle.
  - A start during that done cycle is accepted, giving back-to-back frames.
- Outside strobes: pix_data/pix_row/pix_col hold their last value. pix_valid=0 when nothing is emitted.
- PAD=0: every coordinate is interior and N = IMG_WIDTH*IMG_HEIGHT.
- Exactly N pix_valid strobes and IMG_WIDTH*IMG_HEIGHT mem_rd_en strobes per frame.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- SEQ_PAD_VALUE_EN defined:
  - Adds input pad_value[7:0], latched on accepted start.
  - Pad pixels emit the latched value.
  - Changing pad_value mid-frame has no effect.
- Not defined:
  - Port absent; pad pixels are 0.

Test Plan:
- IMG 4x4, PAD=1, base_addr=0x0100, no stall, mem returns addr[7:0]:
  - 36 pix_valid strobes, 16 reads at 0x0100..0x010F in order.
  - First mem_rd_en at issue index 7 (coord 1,1).
  - pix_data at (1,1)=0x00, (4,4)=0x0F, all border pixels 0.
  - frame_last on (5,5); done 1 cycle later; start->done = 39 cycles.
- Same frame, stall_in high for 5 cycles starting at issue index 10:
  - Identical 36-pixel sequence and addresses; no gaps beyond the stall.
  - At most 2 strobes during stall; done delayed by exactly 5 cycles.
- start pulsed again mid-frame: ignored; single done. Start in the done cycle: second frame starts 1 cycle later with correct addresses.
- rst asserted at issue index 20:
  - All outputs 0 immediately; no done.
  - Fresh start afterwards reproduces scenario 1 exactly.
- PAD=0, 3x3 image: 9 reads, 9 strobes, mem_rd_en on every issue, frame_last on (2,2).
- SEQ_PAD_VALUE_EN with pad_value=0x7F latched, changed to 0x00 mid-frame: all 20 border pixels = 0x7F.
